// File: rtl/up_counter_pkg.sv
// Shared types and default sizes for the up_counter block.
package up_counter_pkg;

  localparam int unsigned DefWidth = 4;
  localparam int unsigned DefWrapW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Next value: clear, else increment until all-ones, then hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/up_counter.sv
// Start/stop up counter with programmable terminal value, one-shot mode,
// synchronous load and a saturating count of terminal events.
module up_counter
  import up_counter_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned WRAP_W = DefWrapW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              en,
  input  logic              oneshot,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [WIDTH-1:0]  mod_val,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              done,
  output logic              busy,
  output logic [WRAP_W-1:0] wrap_cnt
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             wrap_inc, wrap_clr;
  logic             at_term;

  // Anything at or above the terminal value counts as terminal, so a load or
  // a shrinking mod_val never lets the count climb past mod_val.
  assign at_term = (count_q >= mod_val);

  // Next-state, next-count and event decode; priority load > stop > start > count.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    tc_d     = 1'b0;
    wrap_inc = 1'b0;
    wrap_clr = 1'b0;
    if (load) begin
      count_d  = load_val;
      wrap_clr = 1'b1;
    end else if (stop) begin
      // No-op when already idle; start is suppressed on the same edge.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (en) begin
            if (at_term) begin
              tc_d     = 1'b1;
              wrap_inc = 1'b1;
              if (oneshot) begin
                state_d = StDone;
              end else begin
                count_d = '0;
              end
            end else begin
              count_d = count_q + WIDTH'(1);
            end
          end
        end
        StDone: begin
          if (start) begin
            state_d = StRun;
            count_d = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State, count and terminal pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  sat_counter #(
    .Width(WRAP_W)
  ) u_wrap_cnt (
    .clk_i (clk),
    .rst_ni(rst),
    .inc_i (wrap_inc),
    .clr_i (wrap_clr),
    .cnt_o (wrap_cnt)
  );

  assign count = count_q;
  assign tc    = tc_q;
  assign done  = (state_q == StDone);
  assign busy  = (state_q == StRun);

endmodule

// File: tb/tb_up_counter.sv
// Self-checking bench for up_counter: directed scenarios plus a randomized
// run compared against a rule-level reference model.
module tb_up_counter;

  logic       clk;
  logic       rst;
  logic       start, stop, en, oneshot, load;
  logic [3:0] load_val, mod_val;
  logic [3:0] count, count2;
  logic       tc, done, busy, tc2, done2, busy2;
  logic [7:0] wrap_cnt;
  logic [1:0] wrap2;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model (mode: 0 idle, 1 running, 2 finished)
  int         m_mode;
  logic [3:0] m_count;
  logic       m_tc;
  int         m_wrap;

  up_counter #(.WIDTH(4), .WRAP_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en), .oneshot(oneshot),
    .load(load), .load_val(load_val), .mod_val(mod_val), .count(count), .tc(tc),
    .done(done), .busy(busy), .wrap_cnt(wrap_cnt)
  );

  up_counter #(.WIDTH(4), .WRAP_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en), .oneshot(oneshot),
    .load(load), .load_val(load_val), .mod_val(mod_val), .count(count2), .tc(tc2),
    .done(done2), .busy(busy2), .wrap_cnt(wrap2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_mode = 0; m_count = 4'd0; m_tc = 1'b0; m_wrap = 0;
  endfunction

  function automatic void model_step();
    m_tc = 1'b0;
    if (load) begin
      m_count = load_val;
      m_wrap  = 0;
    end else if (stop) begin
      m_mode = 0;
    end else if (start && m_mode != 1) begin
      if (m_mode == 2) m_count = 4'd0;
      m_mode = 1;
    end else if (m_mode == 1 && en) begin
      if (m_count < mod_val) begin
        m_count = m_count + 4'd1;
      end else begin
        m_tc   = 1'b1;
        m_wrap = m_wrap + 1;
        if (oneshot) m_mode = 2;
        else m_count = 4'd0;
      end
    end
  endfunction

  function automatic logic [7:0] exp_w8();
    return (m_wrap > 255) ? 8'd255 : 8'(m_wrap);
  endfunction

  function automatic logic [1:0] exp_w2();
    return (m_wrap > 3) ? 2'd3 : 2'(m_wrap);
  endfunction

  // One clock edge; model follows the same inputs; returns 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; stop = 0; en = 0; oneshot = 0; load = 0;
    load_val = 4'd0; mod_val = 4'd0;
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_tests++; if ({tc, done, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {tc, done, busy}); end
    n_tests++; if (wrap_cnt !== 8'd0 || wrap2 !== 2'd0) begin n_fail++; $display("FAIL reset_wrap got=%0d/%0d exp=0/0", wrap_cnt, wrap2); end
    rst = 1'b1;
    en = 1'b1; mod_val = 4'd9;
    tick(); tick();
    n_tests++; if (busy !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL reset_stay_idle got busy=%b count=%0d exp busy=0 count=0", busy, count); end
  endtask

  task automatic test_free_run();
    mod_val = 4'd9; oneshot = 1'b0; en = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    n_tests++; if (busy !== 1'b1 || count !== 4'd0) begin n_fail++; $display("FAIL free_start got busy=%b count=%0d exp busy=1 count=0", busy, count); end
    for (int i = 0; i < 11; i++) begin
      tick();
      n_tests++; if (count !== 4'((i + 1) % 10)) begin n_fail++; $display("FAIL free_count step=%0d got=%0d exp=%0d", i, count, (i + 1) % 10); end
      n_tests++; if (tc !== (i == 9)) begin n_fail++; $display("FAIL free_tc step=%0d got=%b exp=%b", i, tc, (i == 9)); end
    end
    n_tests++; if (wrap_cnt !== 8'd1) begin n_fail++; $display("FAIL free_wrap got=%0d exp=1", wrap_cnt); end
  endtask

  task automatic test_oneshot();
    load_val = 4'd0; load = 1'b1; tick(); load = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    n_tests++; if (busy !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL os_stop got busy=%b count=%0d exp busy=0 count=0", busy, count); end
    oneshot = 1'b1; mod_val = 4'd5; en = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i < 5) begin
        n_tests++; if (count !== 4'(i + 1) || tc !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL os_count step=%0d got count=%0d tc=%b busy=%b exp count=%0d tc=0 busy=1", i, count, tc, busy, i + 1); end
      end else begin
        n_tests++; if (count !== 4'd5 || tc !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL os_done got count=%0d tc=%b done=%b busy=%b exp 5 1 1 0", count, tc, done, busy); end
      end
    end
    tick();
    n_tests++; if (count !== 4'd5 || tc !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL os_hold got count=%0d tc=%b done=%b exp 5 0 1", count, tc, done); end
    start = 1'b1; tick(); start = 1'b0;
    n_tests++; if (count !== 4'd0 || busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL os_restart got count=%0d busy=%b done=%b exp 0 1 0", count, busy, done); end
  endtask

  task automatic test_load();
    oneshot = 1'b0; mod_val = 4'd7; en = 1'b0;
    load_val = 4'd12; load = 1'b1; tick(); load = 1'b0;
    n_tests++; if (count !== 4'd12 || busy !== 1'b1 || tc !== 1'b0 || wrap_cnt !== 8'd0) begin n_fail++; $display("FAIL load_run got count=%0d busy=%b tc=%b wrap=%0d exp 12 1 0 0", count, busy, tc, wrap_cnt); end
    en = 1'b1; tick();
    n_tests++; if (count !== 4'd0 || tc !== 1'b1 || wrap_cnt !== 8'd1) begin n_fail++; $display("FAIL load_term got count=%0d tc=%b wrap=%0d exp 0 1 1", count, tc, wrap_cnt); end
    stop = 1'b1; tick(); stop = 1'b0;
    load_val = 4'd3; load = 1'b1; start = 1'b1; tick(); load = 1'b0; start = 1'b0;
    n_tests++; if (busy !== 1'b0 || count !== 4'd3) begin n_fail++; $display("FAIL load_vs_start got busy=%b count=%0d exp busy=0 count=3", busy, count); end
    tick();
    n_tests++; if (busy !== 1'b0 || count !== 4'd3) begin n_fail++; $display("FAIL load_idle_hold got busy=%b count=%0d exp busy=0 count=3", busy, count); end
  endtask

  task automatic test_mod_zero();
    load_val = 4'd0; load = 1'b1; tick(); load = 1'b0;
    mod_val = 4'd0; en = 1'b0; oneshot = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      en = (i != 1);
      tick();
      n_tests++; if (count !== 4'd0 || tc !== (i != 1)) begin n_fail++; $display("FAIL mod0 step=%0d got count=%0d tc=%b exp count=0 tc=%b", i, count, tc, (i != 1)); end
    end
  endtask

  task automatic test_wrap_sat();
    mod_val = 4'd1; oneshot = 1'b0; en = 1'b1;
    load_val = 4'd0; load = 1'b1; tick(); load = 1'b0;
    n_tests++; if (wrap2 !== 2'd0) begin n_fail++; $display("FAIL wsat_clear got=%0d exp=0", wrap2); end
    for (int i = 0; i < 10; i++) tick();
    n_tests++; if (wrap2 !== 2'd3) begin n_fail++; $display("FAIL wsat_sat got=%0d exp=3", wrap2); end
    n_tests++; if (wrap_cnt !== 8'd5) begin n_fail++; $display("FAIL wsat_wide got=%0d exp=5", wrap_cnt); end
  endtask

  task automatic test_async_reset();
    mod_val = 4'd9; oneshot = 1'b0; en = 1'b1;
    load_val = 4'd0; load = 1'b1; tick(); load = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    n_tests++; if (count !== 4'd6 || busy !== 1'b1) begin n_fail++; $display("FAIL arst_pre got count=%0d busy=%b exp 6 1", count, busy); end
    #1 rst = 1'b0;
    #1;
    model_reset();
    n_tests++; if (count !== 4'd0 || {tc, done, busy} !== 3'b000) begin n_fail++; $display("FAIL arst_now got count=%0d flags=%b exp 0 000", count, {tc, done, busy}); end
    n_tests++; if (wrap_cnt !== 8'd0 || wrap2 !== 2'd0) begin n_fail++; $display("FAIL arst_wrap got=%0d/%0d exp=0/0", wrap_cnt, wrap2); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_tests++; if (count !== 4'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL arst_idle got count=%0d busy=%b exp 0 0", count, busy); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      load     = ($urandom_range(0, 19) == 0);
      load_val = 4'($urandom_range(0, 15));
      stop     = ($urandom_range(0, 14) == 0);
      start    = ($urandom_range(0, 4) == 0);
      en       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mod_val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) oneshot = ~oneshot;
      tick();
      n_tests++; if (count !== m_count || count2 !== m_count) begin n_fail++; $display("FAIL rand_count cyc=%0d got=%0d/%0d exp=%0d", i, count, count2, m_count); end
      n_tests++; if (tc !== m_tc || tc2 !== m_tc) begin n_fail++; $display("FAIL rand_tc cyc=%0d got=%b/%b exp=%b", i, tc, tc2, m_tc); end
      n_tests++; if (busy !== (m_mode == 1) || done !== (m_mode == 2)) begin n_fail++; $display("FAIL rand_state cyc=%0d got busy=%b done=%b exp mode=%0d", i, busy, done, m_mode); end
      n_tests++; if (wrap_cnt !== exp_w8() || wrap2 !== exp_w2()) begin n_fail++; $display("FAIL rand_wrap cyc=%0d got=%0d/%0d exp=%0d/%0d", i, wrap_cnt, wrap2, exp_w8(), exp_w2()); end
    end
    load = 1'b0; stop = 1'b0; start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_oneshot();
    test_load();
    test_mod_zero();
    test_wrap_sat();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/up_counter.md
UP_COUNTER -- requirements
Module: up_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits.
REQ-002 Parameter WRAP_W, default 8, wrap-event counter width in bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle pulse; begins counting.
REQ-006 stop  input  1  single-cycle pulse; halts counting and holds count.
REQ-007 en  input  1  count enable; while RUN and en=0, count holds.
REQ-008 oneshot  input  1  1 = stop at terminal value; 0 = free-running wrap.
REQ-009 load  input  1  synchronous load strobe.
REQ-010 load_val  input  WIDTH  value written to count on load.
REQ-011 mod_val  input  WIDTH  terminal value; count sequence is 0..mod_val.
REQ-012 count  output  WIDTH  current count, registered.
REQ-013 tc  output  1  registered pulse, high one cycle when count advances from terminal to 0 or into DONE.
REQ-014 done  output  1  high while FSM in DONE.
REQ-015 busy  output  1  high while FSM in RUN.
REQ-016 wrap_cnt  output  WRAP_W  number of terminal events since reset/load, saturating.

Function
REQ-017 FSM states IDLE, RUN, DONE; encoding internal.
REQ-018 IDLE: start=1 -> RUN; otherwise stay; count holds.
REQ-019 RUN: stop=1 -> IDLE with count held; oneshot=1 and en=1 and count>=mod_val -> DONE; otherwise stay.
REQ-020 DONE: start=1 -> RUN with count cleared to 0 on the same edge; stop=1 -> IDLE; count holds.
REQ-021 Input priority on a given edge: load > stop > start > counting.
REQ-022 load=1 in any state: count<=load_val, wrap_cnt<=0, tc<=0, state unchanged.
REQ-023 RUN, en=1, count<mod_val: count<=count+1, tc<=0.
REQ-024 RUN, en=1, count>=mod_val, oneshot=0: count<=0, tc<=1, wrap_cnt increments.
REQ-025 RUN, en=1, count>=mod_val, oneshot=1: count holds, tc<=1, wrap_cnt increments, state<=DONE.
REQ-026 count>mod_val (after load or mod_val change) is treated as terminal per REQ-024/025; no count passes through values above mod_val by incrementing.
REQ-027 mod_val=0: count stays 0 and tc is high every enabled RUN cycle (free-running).
REQ-028 wrap_cnt saturates at 2**WRAP_W-1; never wraps.
REQ-029 tc is 0 in every cycle not covered by REQ-024/025; en=0 forces tc<=0.
REQ-030 start while RUN is ignored; stop while IDLE is ignored.
REQ-031 Latency: an input sampled on edge N is reflected on outputs after edge N; no combinational input-to-output path.

Reset
REQ-032 rst=0 asynchronously forces state IDLE, count=0, tc=0, done=0, busy=0, wrap_cnt=0.
REQ-033 rst asserted mid-RUN or mid-DONE aborts immediately; no terminal event recorded.
REQ-034 After rst deasserts, the block stays in IDLE until start.

Structure
REQ-035 Shared package up_counter_pkg holds the FSM state typedef and the default WIDTH/WRAP_W constants.
REQ-036 One sub-module, sat_counter (parameterised width, inc, clr, saturating), implements wrap_cnt; the main counter and FSM stay in up_counter.

Verification
REQ-037 Reset, start, en=1, oneshot=0, mod_val=9 -> count 0..9,0,1; tc high exactly on the 9->0 edge; wrap_cnt=1.
REQ-038 oneshot=1, mod_val=5, start -> count reaches 5, tc one cycle, done=1, busy=0, count holds 5; second start -> count 0, RUN.
REQ-039 Load load_val=12 with mod_val=7 while RUN -> next enabled edge count=0, tc=1; load with start same cycle -> load wins, state unchanged.
REQ-040 mod_val=0, RUN, en toggling 1,0,1 -> count stays 0; tc high only on en=1 cycles.
REQ-041 WRAP_W=2, mod_val=1, free-run 10 cycles -> wrap_cnt saturates at 3.
REQ-042 rst pulsed low asynchronously at count=6 mid-RUN -> count=0, IDLE, all flags 0 before next clock edge; no counting until start.
